// File: rtl/gf180mcu_fd_sc_mcu9t5v0__mux2_arb.sv
// Two-requester round-robin arbiter driving the select of a mux2 cell.
// Grants, select and captured data word are all flop outputs; MAXHOLD bounds contended hold time.
module gf180mcu_fd_sc_mcu9t5v0__mux2_arb #(
    parameter int WIDTH   = 1,
    parameter int MAXHOLD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             S,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] Z,
    output logic             ZV,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int CW = $clog2(MAXHOLD) + 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    state_t          nxt;
    logic            last;
    logic [CW-1:0]   cnt;
    logic            contend;

    // Power pins exist only for netlist compatibility.
    logic unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    always_comb begin
        nxt     = state;
        contend = 1'b0;
        case (state)
            IDLE: begin
                if (REQ0 && (!REQ1 || last)) nxt = OWN0;
                else if (REQ1)               nxt = OWN1;
            end
            OWN0: begin
                if (!REQ0) begin
                    nxt = REQ1 ? OWN1 : IDLE;
                end else if (REQ1) begin
                    contend = 1'b1;
                    if (cnt == CNT_TOP) nxt = OWN1;
                end
            end
            OWN1: begin
                if (!REQ1) begin
                    nxt = REQ0 ? OWN0 : IDLE;
                end else if (REQ0) begin
                    contend = 1'b1;
                    if (cnt == CNT_TOP) nxt = OWN0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            S     <= 1'b0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            Z     <= '0;
            ZV    <= 1'b0;
        end else begin
            state <= nxt;
            GNT0  <= (nxt == OWN0);
            GNT1  <= (nxt == OWN1);
            // S keeps its last value through IDLE so the mux output stays put.
            if (nxt == OWN0)      S <= 1'b0;
            else if (nxt == OWN1) S <= 1'b1;

            if (nxt != state) begin
                cnt <= '0;
                if (nxt == OWN0)      last <= 1'b0;
                else if (nxt == OWN1) last <= 1'b1;
            end else if (contend) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end

            // Data is captured from the source owning the cycle before this edge.
            case (state)
                OWN0: begin
                    Z  <= I0;
                    ZV <= 1'b1;
                end
                OWN1: begin
                    Z  <= I1;
                    ZV <= 1'b1;
                end
                default: ZV <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__mux2_arb.sv
// Randomized scoreboard bench for the mux2 arbiter, two instances (MAXHOLD=4 and MAXHOLD=1).
module tb_gf180mcu_fd_sc_mcu9t5v0__mux2_arb;

    localparam int W      = 4;
    localparam int NCYC   = 600;

    logic         clk;
    logic         rst;
    logic         req0;
    logic         req1;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    wire          vdd;
    wire          vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    logic         s_a, g0_a, g1_a, zv_a;
    logic [W-1:0] z_a;
    logic         s_b, g0_b, g1_b, zv_b;
    logic [W-1:0] z_b;

    gf180mcu_fd_sc_mcu9t5v0__mux2_arb #(.WIDTH(W), .MAXHOLD(4)) dut_a (
        .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .I0(i0), .I1(i1),
        .S(s_a), .GNT0(g0_a), .GNT1(g1_a), .Z(z_a), .ZV(zv_a), .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu9t5v0__mux2_arb #(.WIDTH(W), .MAXHOLD(1)) dut_b (
        .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .I0(i0), .I1(i1),
        .S(s_b), .GNT0(g0_b), .GNT1(g1_b), .Z(z_b), .ZV(zv_b), .VDD(vdd), .VSS(vss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         s;
        logic         g0;
        logic         g1;
        logic         zv;
        logic [W-1:0] z;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = nobody), previous owner, and a tally of
    // contended cycles in the current tenure; ownership moves once the tally hits MAXHOLD.
    int           m_owner[2];
    int           m_last[2];
    int           m_tally[2];
    logic         m_s[2];
    logic         m_zv[2];
    logic [W-1:0] m_z[2];

    task automatic model_reset(input int d);
        m_owner[d] = -1;
        m_last[d]  = 1;
        m_tally[d] = 0;
        m_s[d]     = 1'b0;
        m_zv[d]    = 1'b0;
        m_z[d]     = '0;
    endtask

    task automatic model_step(input int d, input int maxhold, input logic r,
                              input logic r0, input logic r1,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              output exp_t e);
        int want [2];
        int cur;
        int nw;
        if (r) begin
            model_reset(d);
            nw = -1;
        end else begin
            want[0] = int'(r0);
            want[1] = int'(r1);
            cur = m_owner[d];
            if (cur >= 0) begin
                m_z[d]  = (cur == 1) ? b : a;
                m_zv[d] = 1'b1;
            end else begin
                m_zv[d] = 1'b0;
            end
            if (cur < 0) begin
                if (want[0] == 1 && want[1] == 1) nw = 1 - m_last[d];
                else if (want[0] == 1)            nw = 0;
                else if (want[1] == 1)            nw = 1;
                else                              nw = -1;
            end else if (want[cur] == 0) begin
                nw = (want[1 - cur] == 1) ? 1 - cur : -1;
            end else if (want[1 - cur] == 0) begin
                nw = cur;
                m_tally[d] = 0;
            end else begin
                m_tally[d] = m_tally[d] + 1;
                nw = (m_tally[d] >= maxhold) ? 1 - cur : cur;
            end
            if (nw != cur) begin
                m_tally[d] = 0;
                if (nw >= 0) m_last[d] = nw;
            end
            if (nw >= 0) m_s[d] = (nw == 1);
            m_owner[d] = nw;
        end
        e.s  = m_s[d];
        e.g0 = (nw == 0);
        e.g1 = (nw == 1);
        e.zv = m_zv[d];
        e.z  = m_z[d];
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUTs present registered outputs; check them against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_S",    int'(s_a),  int'(e.s));
                chk("a_GNT0", int'(g0_a), int'(e.g0));
                chk("a_GNT1", int'(g1_a), int'(e.g1));
                chk("a_ZV",   int'(zv_a), int'(e.zv));
                chk("a_Z",    int'(z_a),  int'(e.z));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_S",    int'(s_b),  int'(e.s));
                chk("b_GNT0", int'(g0_b), int'(e.g0));
                chk("b_GNT1", int'(g1_b), int'(e.g1));
                chk("b_ZV",   int'(zv_b), int'(e.zv));
                chk("b_Z",    int'(z_b),  int'(e.z));
            end
        end
    end

    // Stimulus: inputs change 2 time units after a rising edge and are modelled at the next edge.
    initial begin
        exp_t ea;
        exp_t eb;
        int   mode;
        rst  = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        i0   = '0;
        i1   = '0;
        model_reset(0);
        model_reset(1);
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #2;
            mode = (n / 25) % 4;
            rst  = (n < 2) || ($urandom_range(0, 59) == 0);
            i0   = W'($urandom_range(0, (1 << W) - 1));
            i1   = W'($urandom_range(0, (1 << W) - 1));
            case (mode)
                0: begin
                    req0 = 1'($urandom_range(0, 1));
                    req1 = 1'($urandom_range(0, 1));
                end
                1: begin
                    req0 = 1'b1;
                    req1 = 1'b1;
                end
                2: begin
                    req0 = ($urandom_range(0, 9) < 8);
                    req1 = ($urandom_range(0, 9) < 2);
                end
                default: begin
                    req0 = ($urandom_range(0, 9) < 3);
                    req1 = ($urandom_range(0, 9) < 7);
                end
            endcase
            model_step(0, 4, rst, req0, req1, i0, i1, ea);
            model_step(1, 1, rst, req0, req1, i0, i1, eb);
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
